button_conditioner: RTL

- Front-end for the washing-machine controller.
- Takes four raw, bouncy, asynchronous front-panel keys: power, pause, mode and stage.
- Produces the clean one-cycle press pulses that the controller's power_button, pause_button, mode_button and stage_button inputs consume.
- Each key is synchronised, debounced and edge-detected independently; a held-level status vector is also exported.

---
 rtl/washing_machine_pkg.sv | 20 ++
 rtl/key_debounce_channel.sv | 128 ++++++++++++
 rtl/button_conditioner.sv | 76 +++++++
 3 files changed

// File: rtl/washing_machine_pkg.sv
// Shared types and constants for the washing-machine front-panel key conditioning.
package washing_machine_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StHeld        = 2'd2,
        StReleaseWait = 2'd3
    } key_state_e;

    localparam int unsigned NUM_KEYS  = 4;
    localparam int unsigned KEY_POWER = 0;
    localparam int unsigned KEY_PAUSE = 1;
    localparam int unsigned KEY_MODE  = 2;
    localparam int unsigned KEY_STAGE = 3;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 16;

endpackage

// File: rtl/key_debounce_channel.sv
// One front-panel key: two-flop synchroniser, debounce FSM, registered press pulse and held
// level, with an optional auto-repeat counter selected by REPEAT_ALLOWED.
module key_debounce_channel
    import washing_machine_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
    parameter bit          REPEAT_ALLOWED  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse,
    output logic held
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press;
    logic             rpt_fire;
    logic             pulse_q, held_q;

    assign s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (s) begin
                    state_d = StPressWait;
                    cnt_d   = CNT_W'(1);
                end
            end
            StPressWait: begin
                if (!s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StHeld: begin
                if (!s) begin
                    state_d = StReleaseWait;
                    cnt_d   = CNT_W'(1);
                end
            end
            StReleaseWait: begin
                if (s) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    generate
        if (REPEAT_ALLOWED) begin : g_repeat
            localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
            localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
            logic [RPT_W-1:0] rpt_q, rpt_d;

            // Counts only while staying in HELD; any entry or exit restarts the interval.
            always_comb begin
                rpt_d    = '0;
                rpt_fire = 1'b0;
                if (state_q == StHeld && state_d == StHeld) begin
                    if (rpt_q == RPT_LAST) begin
                        rpt_fire = 1'b1;
                    end else begin
                        rpt_d = rpt_q + RPT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rpt_q <= '0;
                end else begin
                    rpt_q <= rpt_d;
                end
            end
        end else begin : g_no_repeat
            assign rpt_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= StIdle;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= press | rpt_fire;
            held_q  <= (state_d == StHeld) || (state_d == StReleaseWait);
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw front-panel keys into one-cycle press pulses and a held-level vector.
// Defining AUTO_REPEAT_EN enables auto-repeat on the mode and stage keys.
module button_conditioner
    import washing_machine_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                power_key,
    input  logic                pause_key,
    input  logic                mode_key,
    input  logic                stage_key,
    output logic                power_button,
    output logic                pause_button,
    output logic                mode_button,
    output logic                stage_button,
    output logic [NUM_KEYS-1:0] key_held
);

`ifdef AUTO_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    key_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_ALLOWED  (1'b0)
    ) u_power (
        .clk   (clk),
        .rst   (rst),
        .key   (power_key),
        .pulse (power_button),
        .held  (key_held[KEY_POWER])
    );

    key_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_ALLOWED  (1'b0)
    ) u_pause (
        .clk   (clk),
        .rst   (rst),
        .key   (pause_key),
        .pulse (pause_button),
        .held  (key_held[KEY_PAUSE])
    );

    key_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_ALLOWED  (REPEAT_EN)
    ) u_mode (
        .clk   (clk),
        .rst   (rst),
        .key   (mode_key),
        .pulse (mode_button),
        .held  (key_held[KEY_MODE])
    );

    key_debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .REPEAT_ALLOWED  (REPEAT_EN)
    ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .key   (stage_key),
        .pulse (stage_button),
        .held  (key_held[KEY_STAGE])
    );

endmodule
